prio_readout_mc: RTL and testbench
==================================

# prio_readout_mc

Multi-channel, parametrised readout controller for the tracklet memory readout. It tracks item counts and read addresses for NCH input memories and selects one non-empty channel per cycle, using either fixed priority or round-robin. It issues one memory read per grant and returns a `valid` strobe aligned to memory read latency. It sits between a bank of NCH event memories and a single downstream consumer, and honours a downstream `stall`.

## Interface
- `NCH`, 4: number of input memory channels (2..16).
- `ADDR_W`, 6: memory address width; per-channel depth is 2^ADDR_W.
- `CNT_W`, ADDR_W+1: item-count width.
- `RD_LAT`, 1: memory read latency in cycles (1..4).
- `RR`, 0: arbitration mode. 0 = fixed priority (lowest index wins); 1 = round-robin.
- `CH_W`, clog2(NCH): channel index width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `initial_count` in NCH*CNT_W: per-channel item count; channel k occupies bits [k*CNT_W +: CNT_W].
- `init` in 1: single-cycle pulse that starts a new crossing.
- `setup` in 1: multi-cycle setup window; no grants while high.
- `stall` in 1: downstream backpressure; no new grant while high.
- `addr` out ADDR_W: read address for the granted channel (registered).
- `rd_ch` out CH_W: granted channel index, qualifies `addr` and `rd_en` (registered).
- `rd_en` out 1: read enable (registered).
- `has_dat` out NCH: per-channel count is non-zero (registered).
- `valid` out 1: memory data valid, RD_LAT cycles after `rd_en`.
- `valid_ch` out CH_W: channel of the data qualified by `valid`.
- `done` out 1: all counts are zero and no reads are in flight.

## Operation
- Per channel there is one count register and one address register.
- **init:** each count loads `min(initial_count[k], 2^ADDR_W)`, i.e. saturates at memory depth. Each address clears to 0. The RD_LAT pipeline flushes, so `valid` is forced to 0 from the next cycle.
- **Request:** `req[k] = (cnt[k] != 0)`.
- **Grant:** `grant_en = ~reset & ~init & ~setup & ~stall & |req`.
  - RR=0: grant goes to the lowest k with `req[k]`.
  - RR=1: grant goes to the first requesting k at or after `ptr` (searching modulo NCH). On each grant, `ptr` becomes granted k + 1, wrapping to 0 after NCH-1. `ptr` resets to 0 on `reset`; `init` does not change it.
- **On grant of channel g:**
  - `cnt[g]` decrements by 1. `addr_r[g]` increments, wrapping modulo 2^ADDR_W; wrap can only occur after the final item.
  - Next cycle: `rd_en`=1, `rd_ch`=g, `addr`= the pre-increment `addr_r[g]`.
- **No grant:** `rd_en`=0; `addr` and `rd_ch` hold their previous values.
- **Valid pipeline:** `valid` and `valid_ch` are `rd_en` and `rd_ch` delayed by RD_LAT. `stall` does not freeze this pipeline; reads already issued complete.
- **has_dat:** `has_dat[k]` is `req[k]` registered.
- **done:** registered; `done = ~|req & ~rd_en & (valid pipeline empty) & ~init`.
- **Priority of simultaneous events:** `reset` > `init` > `setup`/`stall` > grant.

## Timing
- On `reset`, all outputs and state go to 0: counts, addresses, `ptr`, `addr`, `rd_ch`, `rd_en`, `has_dat`, `valid`, `valid_ch`, `done`.
- `init` at edge T: counts are loaded at T. Earliest grant is at edge T+1, giving `rd_en` high after T+1.
- Grant at edge T gives `rd_en` high after T and `valid` high after T+RD_LAT.
- Throughput: one read per cycle while `grant_en`=1.
- Last item: the count reaches 0 on its grant edge. `has_dat` falls one edge later. `done` rises once the pipeline drains.
- `stall` asserted at edge T blocks the grant at T. Reads issued before T still deliver `valid`.
- `init` while reads are in flight: those reads are discarded; `valid` stays 0.
- `initial_count` = 0 for all channels: `done` rises 1 cycle after `init` deasserts, and no `rd_en` occurs.

## Structure
- Shared package `prio_pkg` holds `clog2`, the `RR` mode constants (`PRIO_FIXED`=0, `PRIO_RR`=1) and the default `ADDR_W`/`RD_LAT`.
- Sub-module `prio_arb` is combinational: it takes `req`[NCH] and `ptr`, plus the `RR` parameter, and outputs the grant index and an any-grant flag.
- Per-channel counters are a generate loop in the top module.
- The valid delay line is an RD_LAT-deep shift register in the top module.

## Test plan
- **Fixed priority:** NCH=4, RR=0, counts {2,0,3,1}, then `init`. Expect `rd_en` for 6 consecutive cycles with (ch,addr) = (0,0),(0,1),(2,0),(2,1),(2,2),(3,0). `valid` follows 1 cycle later. `done` rises after the last valid.
- **Round-robin:** RR=1, counts {2,2,2,0}. Grant order is 0,1,2,0,1,2, with addresses 0,0,0,1,1,1.
- **Stall:** assert `stall` for 3 cycles in the middle of a readout. `rd_en` goes low for exactly 3 cycles, the in-flight `valid` still arrives, and no address is skipped or repeated.
- **Saturation:** ADDR_W=6, `initial_count`=100 on channel 0. Expect exactly 64 reads, addresses 0..63, then `has_dat[0]`=0.
- **Re-init:** re-`init` mid-readout with RD_LAT=3. In-flight `valid` is suppressed, and the new counts are read from address 0.
- **Reset:** assert `reset` mid-readout with `setup` high. All outputs go to 0 next cycle, and no grant occurs until after `init`.

Source files
------------

// File: rtl/prio_readout_mc_pkg.sv
// Shared constants and helpers for the priority readout controller.
// Arbitration mode encodings and default memory geometry live here.
package prio_pkg;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_RD_LAT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_readout_mc_if.sv
// Readout bus between the controller (master) and the memory bank / consumer side (slave).
interface prio_readout_if
  import prio_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1,
  parameter int CH_W   = clog2(NCH)
) ();

  logic [NCH*CNT_W-1:0] initial_count;
  logic                 init;
  logic                 setup;
  logic                 stall;
  logic [ADDR_W-1:0]    addr;
  logic [CH_W-1:0]      rd_ch;
  logic                 rd_en;
  logic [NCH-1:0]       has_dat;
  logic                 valid;
  logic [CH_W-1:0]      valid_ch;
  logic                 done;

  modport master (
    input  initial_count, init, setup, stall,
    output addr, rd_ch, rd_en, has_dat, valid, valid_ch, done
  );

  modport slave (
    output initial_count, init, setup, stall,
    input  addr, rd_ch, rd_en, has_dat, valid, valid_ch, done
  );

endinterface

// File: rtl/prio_readout_mc_arb.sv
// Combinational channel arbiter: lowest-index-first, or first request at/after ptr
// when round-robin is selected.
module prio_arb
  import prio_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = clog2(NCH),
  parameter int RR   = PRIO_FIXED
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    logic            found;
    logic [CH_W-1:0] sel;
    int              idx;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (RR == PRIO_RR) ? int'(ptr) + i : i;
      // ptr is always < NCH, so one subtraction is enough for the modulo
      if (idx >= NCH) idx = idx - NCH;
      sel = CH_W'(idx);
      if (!found && req[sel]) begin
        gnt_idx = sel;
        found   = 1'b1;
      end
    end
  end

  assign gnt_any = |req;

endmodule

// File: rtl/prio_readout_mc.sv
// Multi-channel readout controller: per-channel count/address tracking, one read
// per grant, and a valid strobe delayed by the memory read latency.
module prio_readout_mc
  import prio_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int RR     = PRIO_FIXED,
  parameter int CH_W   = clog2(NCH)
) (
  input logic            clk,
  input logic            reset,
  prio_readout_if.master bus
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

  logic [NCH-1:0]                  req;
  logic [ADDR_W-1:0]               addr_r [NCH];
  logic [CH_W-1:0]                 ptr;
  logic [CH_W-1:0]                 gnt_idx;
  logic                            gnt_any;
  logic                            grant_en;

  logic [ADDR_W-1:0]               addr_q;
  logic [CH_W-1:0]                 rd_ch_q;
  logic                            rd_en_q;
  logic [NCH-1:0]                  has_dat_q;
  logic                            done_q;
  logic [RD_LAT-1:0]               vld_sr;
  logic [RD_LAT-1:0][CH_W-1:0]     ch_sr;

  prio_arb #(
    .NCH  (NCH),
    .CH_W (CH_W),
    .RR   (RR)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign grant_en = ~reset & ~bus.init & ~bus.setup & ~bus.stall & gnt_any;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0]  init_cnt;
    logic [CNT_W-1:0]  cnt_k;
    logic [ADDR_W-1:0] addr_k;

    assign init_cnt = bus.initial_count[k*CNT_W +: CNT_W];

    // Counts saturate at memory depth, so the address can only wrap after the last item
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_k  <= '0;
        addr_k <= '0;
      end else if (bus.init) begin
        cnt_k  <= (init_cnt > DEPTH) ? DEPTH : init_cnt;
        addr_k <= '0;
      end else if (grant_en && (gnt_idx == CH_W'(k))) begin
        cnt_k  <= cnt_k - CNT_W'(1);
        addr_k <= addr_k + ADDR_W'(1);
      end
    end

    assign req[k]    = (cnt_k != '0);
    assign addr_r[k] = addr_k;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_en && (RR == PRIO_RR)) begin
      ptr <= (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      rd_ch_q   <= '0;
      rd_en_q   <= 1'b0;
      has_dat_q <= '0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= grant_en;
      if (grant_en) begin
        addr_q  <= addr_r[gnt_idx];
        rd_ch_q <= gnt_idx;
      end
      has_dat_q <= req;
      done_q    <= ~|req & ~rd_en_q & ~|vld_sr & ~bus.init;
    end
  end

  // Stall does not freeze this line; init drops whatever reads are still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      ch_sr  <= '0;
    end else begin
      ch_sr[0] <= rd_ch_q;
      for (int i = 1; i < RD_LAT; i++) ch_sr[i] <= ch_sr[i-1];
      if (bus.init) begin
        vld_sr <= '0;
      end else begin
        vld_sr[0] <= rd_en_q;
        for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign bus.addr     = addr_q;
  assign bus.rd_ch    = rd_ch_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.has_dat  = has_dat_q;
  assign bus.valid    = vld_sr[RD_LAT-1];
  assign bus.valid_ch = ch_sr[RD_LAT-1];
  assign bus.done     = done_q;

endmodule

// File: tb/tb_prio_readout_mc.sv
// Bench for prio_readout_mc: three instances (fixed/RD_LAT=1, round-robin/RD_LAT=1,
// fixed/RD_LAT=3) share one stimulus; each test checks the instance it targets.
module tb_prio_readout_mc;
  localparam int NCH    = 4;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 7;
  localparam int CH_W   = 2;
  localparam int ICW    = NCH * CNT_W;

  typedef struct packed {
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [CH_W-1:0]   valid_ch;
    logic [NCH-1:0]    has_dat;
    logic              done;
  } obs_t;

  typedef struct {
    logic           rst;
    logic           init;
    logic           setup;
    logic           stall;
    logic [ICW-1:0] ic;
    obs_t           exp;
  } vec_t;

  logic           clk;
  logic           reset;
  logic           init;
  logic           setup;
  logic           stall;
  logic [ICW-1:0] ic;
  int             n_cmp = 0;
  int             n_bad = 0;
  vec_t           tbl[$];

  prio_readout_if #(.NCH(NCH), .ADDR_W(ADDR_W)) if_fp ();
  prio_readout_if #(.NCH(NCH), .ADDR_W(ADDR_W)) if_rr ();
  prio_readout_if #(.NCH(NCH), .ADDR_W(ADDR_W)) if_l3 ();

  assign if_fp.initial_count = ic;
  assign if_fp.init          = init;
  assign if_fp.setup         = setup;
  assign if_fp.stall         = stall;
  assign if_rr.initial_count = ic;
  assign if_rr.init          = init;
  assign if_rr.setup         = setup;
  assign if_rr.stall         = stall;
  assign if_l3.initial_count = ic;
  assign if_l3.init          = init;
  assign if_l3.setup         = setup;
  assign if_l3.stall         = stall;

  prio_readout_mc #(.NCH(NCH), .ADDR_W(ADDR_W), .RD_LAT(1), .RR(0)) dut_fp (
    .clk(clk), .reset(reset), .bus(if_fp));
  prio_readout_mc #(.NCH(NCH), .ADDR_W(ADDR_W), .RD_LAT(1), .RR(1)) dut_rr (
    .clk(clk), .reset(reset), .bus(if_rr));
  prio_readout_mc #(.NCH(NCH), .ADDR_W(ADDR_W), .RD_LAT(3), .RR(0)) dut_l3 (
    .clk(clk), .reset(reset), .bus(if_l3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ICW-1:0] pack_ic(input int c0, input int c1, input int c2, input int c3);
    return {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
  endfunction

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0:       o = {if_fp.rd_en, if_fp.rd_ch, if_fp.addr, if_fp.valid, if_fp.valid_ch, if_fp.has_dat, if_fp.done};
      1:       o = {if_rr.rd_en, if_rr.rd_ch, if_rr.addr, if_rr.valid, if_rr.valid_ch, if_rr.has_dat, if_rr.done};
      default: o = {if_l3.rd_en, if_l3.rd_ch, if_l3.addr, if_l3.valid, if_l3.valid_ch, if_l3.has_dat, if_l3.done};
    endcase
    return o;
  endfunction

  function automatic vec_t mk(input logic rst, input logic ini, input logic set, input logic stl,
                              input logic [ICW-1:0] icv, input logic e_en, input int e_ch,
                              input int e_addr, input logic e_v, input int e_vch,
                              input logic [NCH-1:0] e_has, input logic e_done);
    vec_t v;
    v.rst          = rst;
    v.init         = ini;
    v.setup        = set;
    v.stall        = stl;
    v.ic           = icv;
    v.exp.rd_en    = e_en;
    v.exp.rd_ch    = CH_W'(e_ch);
    v.exp.addr     = ADDR_W'(e_addr);
    v.exp.valid    = e_v;
    v.exp.valid_ch = CH_W'(e_vch);
    v.exp.has_dat  = e_has;
    v.exp.done     = e_done;
    return v;
  endfunction

  task automatic chk(input string tn, input int idx, input string fld,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] %s: got %0d expected %0d", tn, idx, fld, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    init  = 1'b0;
    setup = 1'b0;
    stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_table(input string tn, input int d);
    obs_t o;
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      init  = tbl[i].init;
      setup = tbl[i].setup;
      stall = tbl[i].stall;
      ic    = tbl[i].ic;
      tick();
      o = get_obs(d);
      chk(tn, i, "rd_en", o.rd_en, tbl[i].exp.rd_en);
      chk(tn, i, "valid", o.valid, tbl[i].exp.valid);
      chk(tn, i, "has_dat", o.has_dat, tbl[i].exp.has_dat);
      chk(tn, i, "done", o.done, tbl[i].exp.done);
      if (tbl[i].exp.rd_en) begin
        chk(tn, i, "rd_ch", o.rd_ch, tbl[i].exp.rd_ch);
        chk(tn, i, "addr", o.addr, tbl[i].exp.addr);
      end
      if (tbl[i].exp.valid) chk(tn, i, "valid_ch", o.valid_ch, tbl[i].exp.valid_ch);
    end
    tbl.delete();
    reset = 1'b0;
    init  = 1'b0;
    setup = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    obs_t          o;
    logic [ICW-1:0] f_ic;
    logic [ICW-1:0] r_ic;
    int            n;
    logic [ADDR_W-1:0] addrs[$];

    reset = 1'b1;
    init  = 1'b0;
    setup = 1'b0;
    stall = 1'b0;
    ic    = '0;

    // fixed priority, counts {2,0,3,1}
    f_ic = pack_ic(2, 0, 3, 1);
    tbl.push_back(mk(1, 0, 0, 0, f_ic, 0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, f_ic, 0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 1, 0, 0, 0, 0, 4'b1101, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 1, 0, 1, 1, 0, 4'b1101, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 1, 2, 0, 1, 0, 4'b1100, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 1, 2, 1, 1, 2, 4'b1100, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 1, 2, 2, 1, 2, 4'b1100, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 1, 3, 0, 1, 2, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 0, 0, 0, 1, 3, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, f_ic, 0, 0, 0, 0, 0, 4'b0000, 1));
    run_table("fixed", 0);

    // round-robin, counts {2,2,2,0}
    r_ic = pack_ic(2, 2, 2, 0);
    tbl.push_back(mk(1, 0, 0, 0, r_ic, 0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, r_ic, 0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 1, 0, 0, 0, 0, 4'b0111, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 1, 1, 0, 1, 0, 4'b0111, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 1, 2, 0, 1, 1, 4'b0111, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 1, 0, 1, 1, 2, 4'b0111, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 1, 1, 1, 1, 0, 4'b0110, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 1, 2, 1, 1, 1, 4'b0100, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 0, 0, 0, 1, 2, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, r_ic, 0, 0, 0, 0, 0, 4'b0000, 1));
    run_table("rr", 1);

    // stall for 3 cycles in the middle of a 6-item readout
    do_reset();
    ic   = pack_ic(6, 0, 0, 0);
    init = 1'b1;
    tick();
    init = 1'b0;
    addrs.delete();
    for (int c = 1; c <= 14; c++) begin
      stall = (c >= 3 && c <= 5);
      tick();
      o = get_obs(0);
      chk("stall", c, "rd_en", o.rd_en, (c <= 2) || (c >= 6 && c <= 9));
      chk("stall", c, "valid", o.valid, (c >= 2 && c <= 3) || (c >= 7 && c <= 10));
      if (o.rd_en) begin
        chk("stall", c, "rd_ch", o.rd_ch, 0);
        addrs.push_back(o.addr);
      end
    end
    stall = 1'b0;
    chk("stall", 0, "reads", addrs.size(), 6);
    for (int i = 0; i < addrs.size(); i++) chk("stall", i, "addr", addrs[i], i);

    // saturation: 100 clamps to 64, and exactly 64 also reads in full
    do_reset();
    ic   = pack_ic(100, 64, 0, 0);
    init = 1'b1;
    tick();
    init = 1'b0;
    n = 0;
    for (int c = 1; c <= 140; c++) begin
      tick();
      o = get_obs(0);
      if (o.rd_en) begin
        chk("sat", n, "rd_ch", o.rd_ch, n / 64);
        chk("sat", n, "addr", o.addr, n % 64);
        n++;
      end
    end
    chk("sat", 0, "reads", n, 128);
    o = get_obs(0);
    chk("sat", 0, "has_dat", o.has_dat, 0);

    // re-init with RD_LAT=3 while three reads are in flight
    do_reset();
    ic   = pack_ic(5, 0, 0, 0);
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      init = (c == 4);
      if (c == 4) ic = pack_ic(0, 2, 0, 0);
      tick();
      o = get_obs(2);
      chk("reinit", c, "valid", o.valid, (c == 8) || (c == 9));
      if (c <= 3) begin
        chk("reinit", c, "rd_en", o.rd_en, 1);
        chk("reinit", c, "rd_ch", o.rd_ch, 0);
        chk("reinit", c, "addr", o.addr, c - 1);
      end else if (c == 5 || c == 6) begin
        chk("reinit", c, "rd_en", o.rd_en, 1);
        chk("reinit", c, "rd_ch", o.rd_ch, 1);
        chk("reinit", c, "addr", o.addr, c - 5);
      end else begin
        chk("reinit", c, "rd_en", o.rd_en, 0);
      end
      if (c == 8 || c == 9) chk("reinit", c, "valid_ch", o.valid_ch, 1);
    end
    init = 1'b0;

    // reset mid-readout while setup is high
    do_reset();
    ic   = pack_ic(0, 0, 4, 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    tick();
    o = get_obs(0);
    chk("rst", 0, "rd_en", o.rd_en, 1);
    chk("rst", 0, "rd_ch", o.rd_ch, 2);
    chk("rst", 0, "addr", o.addr, 1);
    setup = 1'b1;
    tick();
    o = get_obs(0);
    chk("rst", 1, "rd_en", o.rd_en, 0);
    chk("rst", 1, "valid", o.valid, 1);
    chk("rst", 1, "valid_ch", o.valid_ch, 2);
    reset = 1'b1;
    tick();
    o = get_obs(0);
    chk("rst", 2, "rd_en", o.rd_en, 0);
    chk("rst", 2, "rd_ch", o.rd_ch, 0);
    chk("rst", 2, "addr", o.addr, 0);
    chk("rst", 2, "valid", o.valid, 0);
    chk("rst", 2, "valid_ch", o.valid_ch, 0);
    chk("rst", 2, "has_dat", o.has_dat, 0);
    chk("rst", 2, "done", o.done, 0);
    reset = 1'b0;
    setup = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      o = get_obs(0);
      chk("rst", 3 + k, "rd_en", o.rd_en, 0);
      if (k == 0) chk("rst", 3, "done", o.done, 1);
    end
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    o = get_obs(0);
    chk("rst", 6, "rd_en", o.rd_en, 1);
    chk("rst", 6, "rd_ch", o.rd_ch, 2);
    chk("rst", 6, "addr", o.addr, 0);

    // all counts zero: done one cycle after init drops, no reads
    do_reset();
    ic   = '0;
    init = 1'b1;
    tick();
    init = 1'b0;
    o = get_obs(0);
    chk("zero", 0, "done", o.done, 0);
    chk("zero", 0, "rd_en", o.rd_en, 0);
    tick();
    o = get_obs(0);
    chk("zero", 1, "done", o.done, 1);
    chk("zero", 1, "rd_en", o.rd_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
